// File: rtl/oam_dma_ctl_pkg.sv
// ---------------------------------------------------------------------------
// dma_defs: shared definitions for the sprite (OAM) DMA scheduler.
//   - dma_state_t      : FSM state encoding (3 bits)
//   - DEF_TRIGGER_ADDR : default CPU write address that starts a transfer
//   - DEF_OAM_ADDR     : default destination address for every DMA write
// ---------------------------------------------------------------------------
package dma_defs;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] DEF_TRIGGER_ADDR = 16'h4014;
    localparam logic [15:0] DEF_OAM_ADDR     = 16'h2004;

endpackage

// File: rtl/oam_dma_ctl.sv
// ---------------------------------------------------------------------------
// oam_dma_ctl: sprite-DMA bus scheduler.
// Watches CPU writes for TRIGGER_ADDR, halts the CPU, then copies 256 bytes
// from page {page,00..FF} to OAM_ADDR as read/write pairs. The external top
// level muxes address / rw / write data onto the memory bus with bus_grant.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   cpu_addr     : CPU address bus
//   cpu_wdata    : CPU write data (page number on a trigger)
//   cpu_we       : CPU write strobe
//   mem_rdata    : combinational read data from memory
//   cpu_halt     : stall request to the CPU control unit
//   bus_grant    : 1 = DMA owns the memory bus
//   dma_addr     : DMA address
//   dma_rw       : 1 = read, 0 = write
//   dma_wdata    : DMA write data
//   dma_active   : transfer in progress (same as cpu_halt)
// ---------------------------------------------------------------------------
module oam_dma_ctl
    import dma_defs::*;
#(
    parameter logic [15:0] TRIGGER_ADDR = DEF_TRIGGER_ADDR,
    parameter logic [15:0] OAM_ADDR     = DEF_OAM_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic [7:0]  mem_rdata,
    output logic        cpu_halt,
    output logic        bus_grant,
    output logic [15:0] dma_addr,
    output logic        dma_rw,
    output logic [7:0]  dma_wdata,
    output logic        dma_active
);

    dma_state_t state, state_nxt;
    logic       phase;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data;
    logic       trig;

    assign trig = cpu_we && (cpu_addr == TRIGGER_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            phase <= 1'b0;
            page  <= 8'h00;
            idx   <= 8'h00;
            data  <= 8'h00;
        end else begin
            state <= state_nxt;
            phase <= ~phase;
            if (state == ST_IDLE && trig) begin
                page <= cpu_wdata;
                idx  <= 8'h00;
            end
            if (state == ST_READ)
                data <= mem_rdata;
            // Incrementing on the last WRITE too leaves idx wrapped to 0.
            if (state == ST_WRITE)
                idx <= idx + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (trig) state_nxt = ST_HALT;
            // phase=1 here means the next cycle is a get cycle, so reads can
            // start immediately; otherwise burn one cycle to line up.
            ST_HALT:  state_nxt = phase ? ST_READ : ST_ALIGN;
            ST_ALIGN: state_nxt = ST_READ;
            ST_READ:  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = (idx == 8'hFF) ? ST_IDLE : ST_READ;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Moore decodes; while not writing the bus shows an idle read of {page,idx}.
    always_comb begin
        cpu_halt  = (state == ST_HALT) || (state == ST_ALIGN) ||
                    (state == ST_READ) || (state == ST_WRITE);
        bus_grant = (state == ST_READ) || (state == ST_WRITE);
        dma_rw    = (state != ST_WRITE);
        dma_addr  = (state == ST_WRITE) ? OAM_ADDR : {page, idx};
        dma_wdata = data;
        dma_active = cpu_halt;
    end

endmodule
